deserializer_fsm: RTL and testbench
===================================

// Module: deserializer_fsm
// PURPOSE
//  Receive side of the bit-serial link driven by serializer_fsm in the FIR filter datapath.
//  Accepts one bit per handshake, LSB first, and rebuilds LENGTH-bit words.
//  Presents each word on a registered parallel output with valid/ready backpressure.
//  A one-word skid stage lets the next word shift in while the current word waits downstream.
// PARAMETERS
//  LENGTH  24  word width in bits; legal range >= 2
// PORTS
//  i_clk         in   1       system clock; all state updates on rising edge
//  i_rst         in   1       synchronous reset, active-high
//  i_en          in   1       clock enable; low = every register holds, no transfer on either side
//  i_din         in   1       serial data bit, LSB of word first
//  i_din_valid   in   1       i_din is valid this cycle
//  o_ready       out  1       deserializer can take a bit this cycle
//  ov_dout       out  LENGTH  assembled parallel word
//  o_dout_valid  out  1       ov_dout holds an unconsumed word
//  i_ready       in   1       downstream accepts ov_dout this cycle
// BEHAVIOUR
//  Reset
//   - state=IDLE, counter=0, shift_reg=0, ov_dout=0, o_dout_valid=0.
//   - o_ready=0 while i_rst=1.
//   - Reset mid-word or mid-hold discards all partial and held data.
//  Handshakes
//   - Bit accept: acc = i_en & i_din_valid & o_ready.
//   - Word consume: take = i_en & o_dout_valid & i_ready.
//   - o_ready = ~i_rst & i_en & (state != FULL); no combinational path from i_din_valid or i_ready.
//  States
//   - IDLE: counter==0, no partial word. First acc -> SHIFT_IN, or -> IDLE/FULL directly when LENGTH bits are done.
//   - SHIFT_IN: partial word in shift_reg. Each acc shifts in one bit.
//   - FULL: complete word parked in shift_reg, output register still occupied. o_ready=0.
//  Shift/count rule, on acc
//   - shift_reg <= {i_din, shift_reg[LENGTH-1:1]}.
//   - counter <= counter+1; counter width is $clog2(LENGTH).
//  Word completion (acc while counter==LENGTH-1)
//   - counter <= 0.
//   - If ~o_dout_valid | take: ov_dout <= {i_din, shift_reg[LENGTH-1:1]}, o_dout_valid <= 1, state -> IDLE.
//   - Else: state -> FULL, shift_reg keeps the word.
//   - Latency: word visible on ov_dout the cycle after the last bit is accepted.
//  FULL state
//   - On take: ov_dout <= shift_reg, o_dout_valid stays 1, state -> IDLE, o_ready rises next cycle.
//   - Without take: hold.
//  Output release
//   - take with no new word loaded that cycle -> o_dout_valid <= 0.
//   - take in the same cycle as a completion or FULL reload -> valid stays 1, new word replaces old with no bubble.
//  i_en low
//   - All registers frozen; ov_dout/o_dout_valid stable; gaps in i_din_valid are legal at any point.
// TESTING
//  1 LENGTH=24, i_rst=1 3 cycles with i_din_valid=1, i_din=1
//    -> o_ready=0, o_dout_valid=0, ov_dout=0; after release o_ready=1.
//  2 Send 0xA5C3F1 LSB-first, 24 consecutive bits, i_ready=1
//    -> o_dout_valid=1 for exactly 1 cycle, cycle after 24th bit, ov_dout=0xA5C3F1.
//  3 i_ready=0, send 0x123456 then 0xFEDCBA back-to-back
//    -> first held on ov_dout; after 48th bit o_ready=0 (FULL).
//    -> raise i_ready: 0x123456 consumed, 0xFEDCBA on ov_dout next cycle, o_ready=1 again.
//  4 Send 0x0F0F0F with random i_din_valid gaps and random i_en=0 cycles
//    -> exactly one word 0x0F0F0F, no bits dropped or duplicated.
//  5 Pulse i_rst after 10 bits of 0xFFFFFF, then send 0x000001
//    -> single output word 0x000001, no residue from the aborted word.
//  6 Last bit of 0x00BEEF accepted in the same cycle as take of the prior word 0x111111
//    -> o_dout_valid stays 1, ov_dout changes 0x111111 -> 0x00BEEF.

Source files
------------

// File: rtl/deserializer_fsm.sv
// deserializer_fsm: receive side of the bit-serial link fed by serializer_fsm.
// Rebuilds LENGTH-bit words from an LSB-first bit stream and presents them on a
// registered parallel output with valid/ready flow control. A completed word
// can park in the shift register (FULL) while the output register is occupied.
module deserializer_fsm #(
  parameter int LENGTH = 24
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_en,
  input  logic              i_din,
  input  logic              i_din_valid,
  output logic              o_ready,
  output logic [LENGTH-1:0] ov_dout,
  output logic              o_dout_valid,
  input  logic              i_ready
);

  localparam int CW = $clog2(LENGTH);
  localparam logic [CW-1:0] LAST = CW'(LENGTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT_IN,
    FULL
  } state_t;

  state_t              state, state_nxt;
  logic [CW-1:0]       counter, counter_nxt;
  logic [LENGTH-1:0]   shift_reg, shift_nxt;
  logic [LENGTH-1:0]   dout_nxt;
  logic                valid_nxt;
  logic                acc;
  logic                take;
  logic                last_bit;
  logic [LENGTH-1:0]   shifted;

  // Handshake terms; o_ready depends only on reset, enable and state
  assign o_ready  = ~i_rst & i_en & (state != FULL);
  assign acc      = i_en & i_din_valid & o_ready;
  assign take     = i_en & o_dout_valid & i_ready;
  assign last_bit = (counter == LAST);
  assign shifted  = {i_din, shift_reg[LENGTH-1:1]};

  // Next-state, shift/count and output-register load decisions
  always_comb begin
    state_nxt   = state;
    counter_nxt = counter;
    shift_nxt   = shift_reg;
    dout_nxt    = ov_dout;
    valid_nxt   = o_dout_valid;

    // A consumed output empties unless a new word is loaded below
    if (take) begin
      valid_nxt = 1'b0;
    end

    if (acc) begin
      shift_nxt = shifted;
      if (last_bit) begin
        counter_nxt = '0;
        if (~o_dout_valid | take) begin
          dout_nxt  = shifted;
          valid_nxt = 1'b1;
          state_nxt = IDLE;
        end else begin
          state_nxt = FULL;
        end
      end else begin
        counter_nxt = counter + CW'(1);
        state_nxt   = SHIFT_IN;
      end
    end else if ((state == FULL) && take) begin
      dout_nxt  = shift_reg;
      valid_nxt = 1'b1;
      state_nxt = IDLE;
    end
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state        <= IDLE;
      counter      <= '0;
      shift_reg    <= '0;
      ov_dout      <= '0;
      o_dout_valid <= 1'b0;
    end else begin
      state        <= state_nxt;
      counter      <= counter_nxt;
      shift_reg    <= shift_nxt;
      ov_dout      <= dout_nxt;
      o_dout_valid <= valid_nxt;
    end
  end

endmodule

// File: tb/tb_deserializer_fsm.sv
// tb_deserializer_fsm: directed and randomized bench for deserializer_fsm,
// compared every cycle against a word-queue reference model.
module tb_deserializer_fsm;

  localparam int LENGTH = 24;

  logic              i_clk = 1'b0;
  logic              i_rst;
  logic              i_en;
  logic              i_din;
  logic              i_din_valid;
  logic              o_ready;
  logic [LENGTH-1:0] ov_dout;
  logic              o_dout_valid;
  logic              i_ready;

  deserializer_fsm #(.LENGTH(LENGTH)) dut (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_en         (i_en),
    .i_din        (i_din),
    .i_din_valid  (i_din_valid),
    .o_ready      (o_ready),
    .ov_dout      (ov_dout),
    .o_dout_valid (o_dout_valid),
    .i_ready      (i_ready)
  );

  // Free-running clock
  always #5 i_clk = ~i_clk;

  int checks = 0;
  int passes = 0;

  // Reference model: complete words waiting (front = word on the output),
  // the partially received word, and the value left on the output after a drain
  logic [LENGTH-1:0] word_q[$];
  logic [LENGTH-1:0] part_word = '0;
  int                part_bits = 0;
  logic [LENGTH-1:0] held_val  = '0;
  bit                m_acc     = 1'b0;

  // Words actually consumed from the DUT output, seen at the handshake
  int                obs_words = 0;
  logic [LENGTH-1:0] obs_word  = '0;

  // Global time limit so the bench can never hang
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic applyStimulus(input bit rst, input bit en, input bit din,
                               input bit dv, input bit rdy);
    i_rst       = rst;
    i_en        = en;
    i_din       = din;
    i_din_valid = dv;
    i_ready     = rdy;
  endtask

  // Advance the model by one clock using the inputs present at the edge
  task automatic model_update();
    bit rdy;
    bit take;
    rdy   = !i_rst && i_en && (word_q.size() < 2);
    m_acc = rdy && i_din_valid;
    take  = i_en && (word_q.size() > 0) && i_ready;
    if (i_rst) begin
      word_q.delete();
      part_word = '0;
      part_bits = 0;
      held_val  = '0;
      m_acc     = 1'b0;
    end else begin
      if (take) held_val = word_q.pop_front();
      if (m_acc) begin
        part_word[part_bits] = i_din;
        part_bits++;
        if (part_bits == LENGTH) begin
          word_q.push_back(part_word);
          part_word = '0;
          part_bits = 0;
        end
      end
    end
  endtask

  task automatic checkOutput();
    logic              exp_ready;
    logic [LENGTH-1:0] exp_dout;
    exp_ready = !i_rst && i_en && (word_q.size() < 2);
    exp_dout  = (word_q.size() > 0) ? word_q[0] : held_val;
    chk("o_ready", 64'(o_ready), 64'(exp_ready));
    chk("o_dout_valid", 64'(o_dout_valid), 64'(word_q.size() > 0));
    chk("ov_dout", 64'(ov_dout), 64'(exp_dout));
  endtask

  // One clock: note a downstream take, step the model, check at the falling edge
  task automatic cycle();
    if (i_en && (o_dout_valid === 1'b1) && i_ready) begin
      obs_words++;
      obs_word = ov_dout;
    end
    @(posedge i_clk);
    model_update();
    @(negedge i_clk);
    checkOutput();
  endtask

  // Shift nbits of w (LSB first); optional random valid gaps and enable drops
  task automatic send_bits(input logic [LENGTH-1:0] w, input int nbits,
                           input bit gaps, input bit rdy);
    int idx    = 0;
    int budget = 0;
    bit en_v;
    bit dv;
    while (idx < nbits && budget < 2000) begin
      en_v = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
      dv   = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
      applyStimulus(1'b0, en_v, w[idx], dv, rdy);
      cycle();
      if (m_acc) idx++;
      budget++;
    end
    chk("send_bits_done", 64'(idx), 64'(nbits));
  endtask

  initial begin
    @(negedge i_clk);

    // Reset held three cycles with data offered
    $display("[TB] reset");
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    repeat (3) cycle();
    chk("reset_ready", 64'(o_ready), 64'(0));
    chk("reset_valid", 64'(o_dout_valid), 64'(0));
    chk("reset_dout", 64'(ov_dout), 64'(0));
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    cycle();
    chk("release_ready", 64'(o_ready), 64'(1));

    // Single word, consumed immediately, valid for exactly one cycle
    $display("[TB] single word");
    send_bits(24'hA5C3F1, 24, 1'b0, 1'b1);
    chk("word1_valid", 64'(o_dout_valid), 64'(1));
    chk("word1_dout", 64'(ov_dout), 64'hA5C3F1);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    cycle();
    chk("word1_one_cycle", 64'(o_dout_valid), 64'(0));

    // Backpressure: two words back-to-back fill output and skid stage
    $display("[TB] backpressure");
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    send_bits(24'h123456, 24, 1'b0, 1'b0);
    send_bits(24'hFEDCBA, 24, 1'b0, 1'b0);
    chk("full_ready", 64'(o_ready), 64'(0));
    chk("full_dout", 64'(ov_dout), 64'h123456);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    cycle();
    chk("reload_dout", 64'(ov_dout), 64'hFEDCBA);
    chk("reload_valid", 64'(o_dout_valid), 64'(1));
    chk("reload_ready", 64'(o_ready), 64'(1));
    cycle();

    // Random valid gaps and enable drops inside one word
    $display("[TB] gaps");
    obs_words = 0;
    send_bits(24'h0F0F0F, 24, 1'b1, 1'b1);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    repeat (3) cycle();
    chk("gaps_count", 64'(obs_words), 64'(1));
    chk("gaps_word", 64'(obs_word), 64'h0F0F0F);

    // Reset mid-word discards the partial word
    $display("[TB] abort");
    obs_words = 0;
    send_bits(24'hFFFFFF, 10, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    cycle();
    send_bits(24'h000001, 24, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    repeat (3) cycle();
    chk("abort_count", 64'(obs_words), 64'(1));
    chk("abort_word", 64'(obs_word), 64'h000001);

    // Last bit of a word lands in the same cycle as take of the previous word
    $display("[TB] no-bubble handover");
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    send_bits(24'h111111, 24, 1'b0, 1'b0);
    send_bits(24'h00BEEF, 23, 1'b0, 1'b0);
    chk("handover_before", 64'(ov_dout), 64'h111111);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
    cycle();
    chk("handover_valid", 64'(o_dout_valid), 64'(1));
    chk("handover_dout", 64'(ov_dout), 64'h00BEEF);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    repeat (2) cycle();

    // Fully random traffic with occasional resets
    $display("[TB] random soak");
    for (int n = 0; n < 3000; n++) begin
      applyStimulus($urandom_range(0, 199) == 0, $urandom_range(0, 4) != 0,
                    1'($urandom), $urandom_range(0, 3) != 0,
                    $urandom_range(0, 2) != 0);
      cycle();
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
